// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
// MC_ADDI_EN enables the addi instruction (ADDIEX/ADDIWB states).
package mc_pkg;

    localparam int MC_STATE_W = 4;
    localparam int MC_OP_W    = 6;

    typedef enum logic [MC_STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [MC_OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [MC_OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [MC_OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [MC_OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [MC_OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [MC_OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_B     = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_legal(input logic [MC_OP_W-1:0] op);
        logic r;
        r = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ) || (op == OP_J);
`ifdef MC_ADDI_EN
        r = r || (op == OP_ADDI);
`endif
        return r;
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of the main control FSM.
// ADDIEX/ADDIWB transitions exist only when MC_ADDI_EN is defined.
module mc_next_state
    import mc_pkg::*;
(
    input  state_e              i_state,
    input  logic [MC_OP_W-1:0]  i_opcode,
    output state_e              o_next
);

    always_comb begin
        o_next = S_FETCH;
        case (i_state)
            S_FETCH: o_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: o_next = S_MEMADR;
                    OP_RTYPE:     o_next = S_EXEC;
                    OP_BEQ:       o_next = S_BRANCH;
                    OP_J:         o_next = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      o_next = S_ADDIEX;
`endif
                    default:      o_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (i_opcode == OP_LW)      o_next = S_MEMRD;
                else if (i_opcode == OP_SW) o_next = S_MEMWR;
                else                        o_next = S_FETCH;
            end
            S_MEMRD: o_next = S_MEMWB;
            S_EXEC:  o_next = S_ALUWB;
`ifdef MC_ADDI_EN
            S_ADDIEX: o_next = S_ADDIWB;
`endif
            // Terminal states and unused codes all return to FETCH.
            default: o_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register plus Moore output decode.
// Define MC_ADDI_EN to support addi; otherwise opcode 001000 is illegal.
module mc_main_control
    import mc_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int OP_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_e r_state;
    state_e w_next;
    logic   w_legal;

    mc_next_state u_next (
        .i_state  (r_state),
        .i_opcode (MC_OP_W'(opcode)),
        .o_next   (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    assign w_legal = op_legal(MC_OP_W'(opcode));
    assign state   = STATE_W'(r_state);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = ALUB_FOUR;
                alu_op    = ALUOP_ADD;
                pc_write  = 1'b1;
                pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                // Precompute the branch target; an unknown opcode ends the instruction here.
                alu_src_b  = ALUB_IMMSH;
                alu_op     = ALUOP_ADD;
                illegal_op = !w_legal;
                instr_done = !w_legal;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_B;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALUB_B;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
